// File: rtl/clk_div_pkg.sv
// Shared constants and types for the multi-channel clock divider.
//   CNT_W    : counter / divisor width
//   DEF_DIV  : half-period loaded into every channel at reset
//   MAX_CH   : largest supported channel count
//   CH_SEL_W : width of the channel-select field on the load bus
package clk_div_pkg;

  localparam int CNT_W    = 16;
  localparam int DEF_DIV  = 50;
  localparam int MAX_CH   = 8;
  localparam int CH_SEL_W = 3;

  typedef logic [CNT_W-1:0] div_t;

endpackage

// File: rtl/clk_div_multi_if.sv
// Configuration bus for clk_div_multi.
//   load   : 1-cycle strobe, write div into the shadow of channel ch_sel
//   ch_sel : target channel; values >= N_CH are ignored by the divider
//   div    : new half-period in clock cycles; 0 parks the channel
//   sync   : 1-cycle strobe, restart the phase of every channel
interface clk_div_multi_if;
  import clk_div_pkg::*;

  logic                load;
  logic [CH_SEL_W-1:0] ch_sel;
  div_t                div;
  logic                sync;

  modport master (output load, output ch_sel, output div, output sync);
  modport slave  (input  load, input  ch_sel, input  div, input  sync);

endinterface

// File: rtl/clk_div_channel.sv
// One divider channel: up-counter, active and shadow half-period,
// 50%-duty divided clock (as data), toggle tick and pending flag.
//   i_clk, i_reset_n : clock, async active-low reset
//   i_en             : run enable; low holds count and level
//   i_load, i_div    : write i_div into the shadow divisor
//   i_sync           : clear count and level, apply any pending shadow
//   o_clk            : divided clock level
//   o_tick           : high for the cycle following each o_clk toggle edge
//   o_pending        : shadow divisor not yet applied
module clk_div_channel
  import clk_div_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_en,
  input  logic i_load,
  input  logic i_sync,
  input  div_t i_div,
  output logic o_clk,
  output logic o_tick,
  output logic o_pending
);

  div_t cnt_q, cnt_d;
  div_t act_q, act_d;
  div_t shd_q, shd_d;
  logic clk_q, clk_d;
  logic tick_q, tick_d;
  logic pend_q, pend_d;
  logic wrap;

  // Only meaningful when act_q != 0; the park branch is taken first otherwise.
  assign wrap = (cnt_q == (act_q - CNT_W'(1)));

  always_comb begin
    cnt_d  = cnt_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    act_d  = act_q;
    shd_d  = i_load ? i_div : shd_q;
    pend_d = i_load | pend_q;

    if (i_sync) begin
      // A load in the same cycle is already in shd_d, so the sync applies it.
      cnt_d  = '0;
      clk_d  = 1'b0;
      if (i_load || pend_q) act_d = shd_d;
      pend_d = 1'b0;
    end else if ((act_q == '0) || !i_en) begin
      // Parked or stopped: no half-period in flight, apply right away.
      if (pend_q) begin
        act_d  = shd_q;
        cnt_d  = '0;
        pend_d = i_load;
      end
    end else if (wrap) begin
      cnt_d  = '0;
      clk_d  = ~clk_q;
      tick_d = 1'b1;
      // Swap only on a half-period boundary so no runt half-period appears.
      if (pend_q) begin
        act_d  = shd_q;
        pend_d = i_load;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (act_d == '0) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end

    // A tick marks a real level change only (e.g. parking from a low level).
    tick_d = tick_d & (clk_d != clk_q);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q  <= '0;
      act_q  <= CNT_W'(DEF_DIV);
      shd_q  <= CNT_W'(DEF_DIV);
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      pend_q <= pend_d;
    end
  end

  assign o_clk     = clk_q;
  assign o_tick    = tick_q;
  assign o_pending = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// N-channel programmable clock divider / tick generator.
//   i_clk, i_reset_n : system clock, async active-low reset
//   i_en             : per-channel run enable
//   cfg              : load / channel select / divisor / sync bus
//   o_clk            : divided clocks (registered data, never a clock)
//   o_tick           : 1-cycle pulse per o_clk toggle
//   o_pending        : shadow divisor waiting to be applied
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [N_CH-1:0]   i_en,
  clk_div_multi_if.slave    cfg,
  output logic [N_CH-1:0]   o_clk,
  output logic [N_CH-1:0]   o_tick,
  output logic [N_CH-1:0]   o_pending
);

  logic [N_CH-1:0] ch_load;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    // Selects beyond the last channel match nothing and are dropped.
    assign ch_load[g] = cfg.load && (cfg.ch_sel == CH_SEL_W'(g));

    clk_div_channel u_ch (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_en      (i_en[g]),
      .i_load    (ch_load[g]),
      .i_sync    (cfg.sync),
      .i_div     (cfg.div),
      .o_clk     (o_clk[g]),
      .o_tick    (o_tick[g]),
      .o_pending (o_pending[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;
  import clk_div_pkg::*;

  localparam int N_CH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N_CH-1:0] en;
  logic [N_CH-1:0] o_clk, o_tick, o_pending;

  clk_div_multi_if cfg ();

  clk_div_multi #(.N_CH(N_CH)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_en      (en),
    .cfg       (cfg),
    .o_clk     (o_clk),
    .o_tick    (o_tick),
    .o_pending (o_pending)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n = 0;

  // Reference model: remaining cycles to next toggle, level, divisors.
  int m_act[N_CH], m_shd[N_CH], m_rem[N_CH];
  bit m_lvl[N_CH], m_tick[N_CH], m_pend[N_CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_act[c] = DEF_DIV; m_shd[c] = DEF_DIV; m_rem[c] = DEF_DIV;
      m_lvl[c] = 0; m_tick[c] = 0; m_pend[c] = 0;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < N_CH; c++) begin
      bit ld;
      bit old;
      ld  = cfg.load && (int'(cfg.ch_sel) == c);
      old = m_lvl[c];
      m_tick[c] = 0;
      if (cfg.sync) begin
        if (ld) m_shd[c] = int'(cfg.div);
        if (ld || m_pend[c]) m_act[c] = m_shd[c];
        m_pend[c] = 0;
        m_lvl[c]  = 0;
        m_rem[c]  = m_act[c];
      end else if (m_act[c] == 0 || !en[c]) begin
        if (m_pend[c]) begin
          m_act[c] = m_shd[c]; m_pend[c] = 0; m_rem[c] = m_act[c];
        end
        if (ld) begin m_shd[c] = int'(cfg.div); m_pend[c] = 1; end
        if (m_act[c] == 0) m_lvl[c] = 0;
      end else begin
        m_rem[c]--;
        if (m_rem[c] == 0) begin
          m_lvl[c] = !m_lvl[c];
          if (m_pend[c]) begin m_act[c] = m_shd[c]; m_pend[c] = 0; end
          if (m_act[c] == 0) m_lvl[c] = 0;
          m_tick[c] = (m_lvl[c] != old);
          m_rem[c]  = m_act[c];
        end
        if (ld) begin m_shd[c] = int'(cfg.div); m_pend[c] = 1; end
      end
    end
  endtask

  task automatic cyc();
    logic [N_CH-1:0] e_clk, e_tick, e_pend;
    @(posedge clk);
    model_edge();
    n++;
    #1;
    for (int c = 0; c < N_CH; c++) begin
      e_clk[c] = m_lvl[c]; e_tick[c] = m_tick[c]; e_pend[c] = m_pend[c];
    end
    check("o_clk",     32'(o_clk),     32'(e_clk));
    check("o_tick",    32'(o_tick),    32'(e_tick));
    check("o_pending", 32'(o_pending), 32'(e_pend));
  endtask

  task automatic load_cfg(input int sel, input int div, input bit sync);
    cfg.load = 1'b1; cfg.ch_sel = CH_SEL_W'(sel); cfg.div = CNT_W'(div); cfg.sync = sync;
    cyc();
    cfg.load = 1'b0; cfg.sync = 1'b0;
  endtask

  initial begin
    int first, cnt, t0, held;
    int ft[N_CH];
    en = '1;
    cfg.load = 0; cfg.ch_sel = '0; cfg.div = '0; cfg.sync = 0;
    model_reset();
    #12;
    check("reset_clk",  32'(o_clk),     0);
    check("reset_tick", 32'(o_tick),    0);
    check("reset_pend", 32'(o_pending), 0);
    @(negedge clk) rst_n = 1'b1;

    // 1: default divisor, all enabled
    first = -1; cnt = 0;
    for (int i = 0; i < 120; i++) begin
      cyc();
      if (o_clk[0] && first < 0) first = n;
      if (o_tick[0]) cnt++;
    end
    check("first_rise_def", first, 50);
    check("ticks_120", cnt, 2);

    // 2: ch1 -> 3 mid half-period
    load_cfg(1, 3, 0);
    check("pend1_set", 32'(o_pending[1]), 1);
    first = -1;
    for (int i = 0; i < 60 && first < 0; i++) begin
      cyc();
      if (o_tick[1]) first = n;
    end
    check("pend1_wrap_seen", 32'(first >= 0), 1);
    check("pend1_clr", 32'(o_pending[1]), 0);
    for (int k = 0; k < 2; k++) begin
      t0 = n; first = -1;
      for (int i = 0; i < 10 && first < 0; i++) begin
        cyc();
        if (o_tick[1]) first = n;
      end
      check("half_period_3", first - t0, 3);
    end

    // 3: ch2 park, then divide by 1
    load_cfg(2, 0, 0);
    for (int i = 0; i < 110 && o_pending[2]; i++) cyc();
    check("pend2_clr", 32'(o_pending[2]), 0);
    cnt = 0; held = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (o_tick[2]) cnt++;
      if (o_clk[2]) held++;
    end
    check("park_ticks", cnt, 0);
    check("park_clk", held, 0);
    load_cfg(2, 1, 0);
    cyc();
    cnt = 0; held = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (o_tick[2]) cnt++;
      if (o_clk[2]) held++;
    end
    check("div1_ticks", cnt, 10);
    check("div1_high", held, 5);

    // 4: div 2,5,7 and sync (ch3 load coincides with sync)
    load_cfg(0, 2, 0);
    load_cfg(1, 5, 0);
    load_cfg(3, 7, 1);
    check("sync_clk_low", 32'(o_clk), 0);
    check("sync_no_tick", 32'(o_tick), 0);
    for (int c = 0; c < N_CH; c++) ft[c] = -1;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      for (int c = 0; c < N_CH; c++) if (o_tick[c] && ft[c] < 0) ft[c] = i;
    end
    check("sync_ft0", ft[0], 2);
    check("sync_ft1", ft[1], 5);
    check("sync_ft3", ft[3], 7);

    // 5: pause ch0 at count 20 for 10 cycles
    load_cfg(0, 50, 1);
    for (int i = 0; i < 20; i++) cyc();
    en[0] = 1'b0;
    held = o_clk[0]; cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (o_clk[0] != held[0]) cnt++;
      if (o_tick[0]) cnt++;
    end
    check("hold_stable", cnt, 0);
    en[0] = 1'b1;
    first = -1;
    for (int i = 1; i <= 40 && first < 0; i++) begin
      cyc();
      if (o_tick[0]) first = i;
    end
    check("resume_toggle", first, 30);

    // 6: reset with a pending load and an out-of-range select
    load_cfg(3, 100, 0);
    check("pend3_set", 32'(o_pending[3]), 1);
    load_cfg(7, 9, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_clk",  32'(o_clk),     0);
    check("arst_tick", 32'(o_tick),    0);
    check("arst_pend", 32'(o_pending), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    en = '1;
    n = 0; first = -1;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (o_clk[3] && first < 0) first = n;
    end
    check("post_rst_rise3", first, 50);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < N_CH; c++) en[c] = ($urandom_range(0, 9) != 0);
      cfg.load   = ($urandom_range(0, 7) == 0);
      cfg.ch_sel = CH_SEL_W'($urandom_range(0, 7));
      cfg.div    = CNT_W'($urandom_range(0, 8));
      cfg.sync   = ($urandom_range(0, 39) == 0);
      cyc();
    end
    cfg.load = 0; cfg.sync = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
